uart_rx_fsm: RTL and testbench

//  - Receives the serial frame produced by the team's UART transmitter and delivers parallel bytes.
//  - Frame: start(0), 8 data bits MSB first, even parity (^data), stop(1). Line idles at 1.
//  - Oversamples serial_in on clk_baud at OVERSAMPLE x bit rate.
//  - Downstream of the TX serial line; feeds byte consumers through data_out/data_valid.

---
 rtl/uart_rx_fsm.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// Oversampling UART receiver: start, 8 data bits MSB first, even parity, stop.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote around the sample point.
module uart_rx_fsm #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_baud,
    input  logic       rst,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam int TW   = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam int VOTE_DLY = 1;
`else
    localparam int VOTE_DLY = 0;
`endif
    localparam logic [TW-1:0] START_TICK = TW'(HALF - 1 + VOTE_DLY);
    localparam logic [TW-1:0] BIT_TICK   = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            par_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            prev_q;
    logic            start_edge_s;
    logic            sample_s;
    logic            bit_end_s;

`ifdef UART_RX_MAJORITY_EN
    logic            prev2_q;

    // Synchronizer plus two history taps so the vote sees S-1, S and S+1
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            prev2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            prev2_q <= prev_q;
        end
    end

    assign sample_s = maj3(prev2_q, prev_q, sync2_q);
`else
    // Two-flop synchronizer plus the edge-detect history flop
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign sample_s = sync2_q;
`endif

    assign start_edge_s = prev_q & ~sync2_q;
    assign bit_end_s    = (tick_q == BIT_TICK);

    // Frame sequencer; all outputs are registered here
    always_ff @(posedge clk_baud or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge_s) begin
                        tick_q  <= '0;
                        busy    <= 1'b1;
                        state_q <= ST_START;
                    end else begin
                        tick_q  <= '0;
                    end
                end
                ST_START: begin
                    if (tick_q == START_TICK) begin
                        tick_q <= '0;
                        if (sample_s) begin
                            busy    <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            bit_q   <= 3'd0;
                            state_q <= ST_DATA;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        tick_q  <= '0;
                        shift_q <= {shift_q[6:0], sample_s};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) begin
                        tick_q  <= '0;
                        par_q   <= sample_s;
                        state_q <= ST_STOP;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    // Leave mid-stop-bit so a zero-gap next start edge is still caught
                    if (bit_end_s) begin
                        tick_q     <= '0;
                        data_valid <= 1'b1;
                        data_out   <= shift_q;
                        parity_err <= par_q ^ even_parity(shift_q);
                        frame_err  <= ~sample_s;
                        busy       <= 1'b0;
                        state_q    <= ST_IDLE;
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                default: begin
                    tick_q  <= '0;
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed frames with literal expectations plus random traffic,
// all checked every cycle against a frame model computed from the sampled line history.
module tb_uart_rx_fsm;

    localparam int OS   = 16;
    localparam int HALF = OS / 2;
    localparam int FLEN = 11 * OS;
    localparam int HMAX = 32768;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk_baud = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx_fsm #(.OVERSAMPLE(OS)) dut (
        .clk_baud   (clk_baud),
        .rst        (rst),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk_baud = ~clk_baud;

    int   checks = 0;
    int   errors = 0;
    logic line_h [0:HMAX-1];
    int   p = 0;
    int   dv_count = 0;
    int   dv_prev_p = 0;
    int   dv_last_p = 0;
    logic [7:0] dv_data_q [$];
    logic cap_pe;
    logic cap_fe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at cycle %0d", nm, act, exp, p);
        end
    endtask

    // Value of the synchronized line during cycle x (line sampled one edge earlier)
    function automatic logic sv(input int x);
        if (x < 1 || x > HMAX) return 1'b1;
        return line_h[x-1];
    endfunction

    function automatic logic vote(input int s);
        logic a, b, c;
        a = sv(s - 1);
        b = sv(s);
        c = sv(s + 1);
        if (MAJ == 1) return (a & b) | (a & c) | (b & c);
        return b;
    endfunction

    // Record the line value seen at each active edge (reset forces idle-high)
    initial begin
        forever begin
            @(posedge clk_baud);
            p = p + 1;
            if (p < HMAX) line_h[p] = rst ? 1'b1 : serial_in;
        end
    end

    // Reference frame model and per-cycle compare
    initial begin
        logic       m_idle;
        int         m_e;
        int         c;
        logic [7:0] e_data;
        logic       e_dv, e_pe, e_fe, e_busy;
        logic [7:0] b;
        logic       par, stp;
        m_idle = 1'b1; m_e = 0;
        e_data = 8'h00; e_dv = 1'b0; e_pe = 1'b0; e_fe = 1'b0; e_busy = 1'b0;
        forever begin
            @(negedge clk_baud);
            if (rst) begin
                m_idle = 1'b1;
                e_data = 8'h00; e_dv = 1'b0; e_pe = 1'b0; e_fe = 1'b0; e_busy = 1'b0;
            end else begin
                c = p - 1;
                e_dv = 1'b0;
                if (m_idle) begin
                    if (c >= 2 && sv(c) == 1'b0 && sv(c - 1) == 1'b1) begin
                        m_idle = 1'b0;
                        m_e    = c;
                        e_busy = 1'b1;
                    end
                end else if (c == m_e + HALF + MAJ && vote(m_e + HALF) == 1'b1) begin
                    m_idle = 1'b1;
                    e_busy = 1'b0;
                end else if (c == m_e + HALF + 10 * OS + MAJ) begin
                    for (int i = 0; i < 8; i++) b[7-i] = vote(m_e + HALF + (i + 1) * OS);
                    par    = vote(m_e + HALF + 9 * OS);
                    stp    = vote(m_e + HALF + 10 * OS);
                    e_data = b;
                    e_pe   = par ^ (^b);
                    e_fe   = ~stp;
                    e_dv   = 1'b1;
                    e_busy = 1'b0;
                    m_idle = 1'b1;
                end
            end
            chk("model_data_valid", {31'd0, data_valid}, {31'd0, e_dv});
            chk("model_data_out", {24'd0, data_out}, {24'd0, e_data});
            chk("model_parity_err", {31'd0, parity_err}, {31'd0, e_pe});
            chk("model_frame_err", {31'd0, frame_err}, {31'd0, e_fe});
            chk("model_busy", {31'd0, busy}, {31'd0, e_busy});
            if (data_valid === 1'b1) begin
                dv_count++;
                dv_prev_p = dv_last_p;
                dv_last_p = p;
                dv_data_q.push_back(data_out);
                cap_pe = parity_err;
                cap_fe = frame_err;
            end
        end
    end

    task automatic hold(input logic v, input int n);
        serial_in = v;
        repeat (n) begin
            @(posedge clk_baud);
            #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stp, input int gk);
        logic v;
        for (int k = 0; k < FLEN; k++) begin
            int bi;
            bi = k / OS;
            if (bi == 0) v = 1'b0;
            else if (bi <= 8) v = d[8-bi];
            else if (bi == 9) v = par;
            else v = stp;
            if (k == gk) v = ~v;
            serial_in = v;
            @(posedge clk_baud);
            #1;
        end
    endtask

    initial begin
        int n0;
        for (int i = 0; i < HMAX; i++) line_h[i] = 1'b1;
        rst = 1'b1;
        serial_in = 1'b1;
        repeat (3) @(posedge clk_baud);
        #1;
        chk("reset_data_out", {24'd0, data_out}, 32'h0);
        chk("reset_data_valid", {31'd0, data_valid}, 32'h0);
        chk("reset_parity_err", {31'd0, parity_err}, 32'h0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        hold(1'b1, 20);

        // Clean frame
        n0 = dv_count;
        drive_frame(8'hA5, 1'b0, 1'b1, -1);
        hold(1'b1, 10);
        chk("a5_pulses", dv_count, n0 + 1);
        chk("a5_data", {24'd0, dv_data_q[$]}, 32'hA5);
        chk("a5_perr", {31'd0, cap_pe}, 32'h0);
        chk("a5_ferr", {31'd0, cap_fe}, 32'h0);
        chk("a5_busy", {31'd0, busy}, 32'h0);

        // Wrong parity
        n0 = dv_count;
        drive_frame(8'h01, 1'b0, 1'b1, -1);
        hold(1'b1, 10);
        chk("p01_pulses", dv_count, n0 + 1);
        chk("p01_data", {24'd0, dv_data_q[$]}, 32'h01);
        chk("p01_perr", {31'd0, cap_pe}, 32'h1);
        chk("p01_ferr", {31'd0, cap_fe}, 32'h0);

        // Bad stop followed by a break
        n0 = dv_count;
        drive_frame(8'h3C, 1'b0, 1'b0, -1);
        hold(1'b0, 40);
        chk("brk_pulses", dv_count, n0 + 1);
        chk("brk_data", {24'd0, dv_data_q[$]}, 32'h3C);
        chk("brk_ferr", {31'd0, cap_fe}, 32'h1);
        chk("brk_perr", {31'd0, cap_pe}, 32'h0);
        hold(1'b1, 20);
        chk("brk_no_more", dv_count, n0 + 1);

        // False start
        n0 = dv_count;
        hold(1'b0, 4);
        chk("fs_busy_hi", {31'd0, busy}, 32'h1);
        hold(1'b1, 10);
        chk("fs_busy_lo", {31'd0, busy}, 32'h0);
        chk("fs_no_pulse", dv_count, n0);

        // Back-to-back, zero gap
        n0 = dv_count;
        drive_frame(8'h55, 1'b0, 1'b1, -1);
        drive_frame(8'hAA, 1'b0, 1'b1, -1);
        hold(1'b1, 10);
        chk("b2b_pulses", dv_count, n0 + 2);
        chk("b2b_spacing", dv_last_p - dv_prev_p, 176);
        chk("b2b_first", {24'd0, dv_data_q[$-1]}, 32'h55);
        chk("b2b_second", {24'd0, dv_data_q[$]}, 32'hAA);
        chk("b2b_perr", {31'd0, cap_pe}, 32'h0);

        // Reset in the middle of a frame
        n0 = dv_count;
        hold(1'b0, 16);
        hold(1'b1, 64);
        chk("mid_busy", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, data_out}, 32'h0);
        chk("mid_rst_busy", {31'd0, busy}, 32'h0);
        chk("mid_rst_dv", {31'd0, data_valid}, 32'h0);
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 10);
        chk("mid_no_pulse", dv_count, n0);
        drive_frame(8'h81, 1'b0, 1'b1, -1);
        hold(1'b1, 10);
        chk("mid_after_pulses", dv_count, n0 + 1);
        chk("mid_after_data", {24'd0, dv_data_q[$]}, 32'h81);

        // One-cycle glitch on data bit 3 at its sample point
        n0 = dv_count;
        drive_frame(8'h00, 1'b0, 1'b1, OS + 3 * OS + HALF);
        hold(1'b1, 10);
        chk("glitch_pulses", dv_count, n0 + 1);
        chk("glitch_data", {24'd0, dv_data_q[$]}, (MAJ == 1) ? 32'h00 : 32'h10);
        chk("glitch_perr", {31'd0, cap_pe}, (MAJ == 1) ? 32'h0 : 32'h1);

        // Random traffic: frames, bad parity/stop, glitches, false starts, gaps
        for (int r = 0; r < 40; r++) begin
            logic [7:0] d;
            logic       par, stp;
            int         gk;
            if ($urandom_range(0, 9) == 0) begin
                hold(1'b0, $urandom_range(1, 6));
                hold(1'b1, 12);
            end else begin
                d   = 8'($urandom_range(0, 255));
                par = ^d;
                if ($urandom_range(0, 3) == 0) par = ~par;
                stp = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
                gk  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, FLEN - 1) : -1;
                drive_frame(d, par, stp, gk);
                if ($urandom_range(0, 3) != 0) hold(1'b1, $urandom_range(1, 30));
            end
        end
        hold(1'b1, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
